// File: rtl/timer_sched_if.sv
// Memory-mapped data bus between a requester and the timer/scheduler block.
interface timer_sched_if;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/timer_sched.sv
// Free-running 32-bit counter with N_CH wrap-safe compare channels, optional
// periodic reload, sticky pending bits and a level interrupt.
module timer_sched #(
  parameter int unsigned N_CH = 4,
  parameter logic [19:0] BASE = 20'h00022
) (
  input  logic         clk,
  input  logic         rst,
  timer_sched_if.slave bus,
  output logic         irq
);
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 12;

  typedef struct packed {
    logic          we;
    logic [3:0]    be;
    logic [OW-1:0] off;
    logic [DW-1:0] wdata;
  } acc_t;

  // Encoding doubles as the registered handshake: bit0 = gnt, bit1 = rvalid.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_GNT  = 2'b01,
    S_RSP  = 2'b10
  } state_t;

  state_t                  state, state_nxt;
  acc_t                    acc;
  logic                    hit_c;
  logic                    wr_acc, wr_ctrl, wr_pend;
  logic [N_CH-1:0]         ch_hit, wr_cmp, wr_per, wr_cc;
  logic [N_CH-1:0]         fire, reload, w1c;
  logic [DW-1:0]           count;
  logic                    run;
  logic [N_CH-1:0][DW-1:0] cmp, period;
  logic [N_CH-1:0]         en, per_mode, irq_en, pend;
  logic [3:0]              low_pend;
  logic [DW-1:0]           rd_val, rdata;

  assign hit_c = bus.data_req && (bus.data_addr[31:12] == BASE);

  assign bus.data_gnt    = state[0];
  assign bus.data_rvalid = state[1];
  assign bus.data_rdata  = rdata;
  assign irq             = |(pend & irq_en);

  // Handshake state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next state: grant a decoded request unless a grant is already showing
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_GNT:   state_nxt = S_RSP;
      default: if (hit_c) state_nxt = S_GNT;
    endcase
  end

  // Capture the accepted request and the read data of the granted access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      rdata <= '0;
    end else begin
      if (state_nxt == S_GNT) begin
        acc.we    <= bus.data_we;
        acc.be    <= bus.data_be;
        acc.off   <= bus.data_addr[OW-1:0];
        acc.wdata <= bus.data_wdata;
      end
      if (state == S_GNT) rdata <= acc.we ? '0 : rd_val;
    end
  end

  // Register write strobes, effective in the grant cycle
  always_comb begin
    wr_acc  = (state == S_GNT) && acc.we;
    wr_ctrl = wr_acc && (acc.off == 12'h004) && acc.be[0];
    wr_pend = wr_acc && (acc.off == 12'h008) && acc.be[0];
    ch_hit  = '0;
    wr_cmp  = '0;
    wr_per  = '0;
    wr_cc   = '0;
    for (int n = 0; n < int'(N_CH); n++) begin
      ch_hit[n] = (acc.off[OW-1:4] == 8'(n + 1));
      wr_cmp[n] = wr_acc && ch_hit[n] && (acc.off[3:0] == 4'h0);
      wr_per[n] = wr_acc && ch_hit[n] && (acc.off[3:0] == 4'h4);
      wr_cc[n]  = wr_acc && ch_hit[n] && (acc.off[3:0] == 4'h8) && acc.be[0];
    end
    w1c = wr_pend ? acc.wdata[N_CH-1:0] : '0;
  end

  // Counter: clear from CTRL beats the increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      run   <= 1'b0;
    end else begin
      if (wr_ctrl) run <= acc.wdata[1];
      if (wr_ctrl && acc.wdata[0]) count <= '0;
      else if (run)                count <= count + 32'd1;
    end
  end

  // Fire when COUNT is at or past CMP within half the counter range
  always_comb begin
    fire   = '0;
    reload = '0;
    for (int n = 0; n < int'(N_CH); n++) begin
      fire[n]   = en[n] && ((count - cmp[n]) < 32'h8000_0000);
      reload[n] = per_mode[n] && (period[n] != '0);
    end
  end

  // Channel registers: bus writes take priority over fire-driven updates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp      <= '0;
      period   <= '0;
      en       <= '0;
      per_mode <= '0;
      irq_en   <= '0;
    end else begin
      for (int n = 0; n < int'(N_CH); n++) begin
        if (wr_cmp[n]) begin
          for (int b = 0; b < 4; b++)
            if (acc.be[b]) cmp[n][8*b +: 8] <= acc.wdata[8*b +: 8];
        end else if (fire[n] && reload[n]) begin
          cmp[n] <= cmp[n] + period[n];
        end
        if (wr_per[n]) begin
          for (int b = 0; b < 4; b++)
            if (acc.be[b]) period[n][8*b +: 8] <= acc.wdata[8*b +: 8];
        end
        if (wr_cc[n]) begin
          en[n]       <= acc.wdata[0];
          per_mode[n] <= acc.wdata[1];
          irq_en[n]   <= acc.wdata[2];
        end else if (fire[n] && !reload[n]) begin
          en[n] <= 1'b0;
        end
      end
    end
  end

  // Pending bits: a fire in the same cycle overrides a write-one-to-clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend <= '0;
    else      pend <= (pend & ~w1c) | fire;
  end

  // Lowest-index pending channel, 4'hF when none
  always_comb begin
    low_pend = 4'hF;
    for (int n = int'(N_CH) - 1; n >= 0; n--)
      if (pend[n]) low_pend = 4'(n);
  end

  // Read mux for the granted offset
  always_comb begin
    rd_val = '0;
    case (acc.off)
      12'h000: rd_val = count;
      12'h008: rd_val = DW'(pend);
      12'h00C: rd_val = {20'h0, low_pend, 7'h0, run};
      default: rd_val = '0;
    endcase
    for (int n = 0; n < int'(N_CH); n++) begin
      if (ch_hit[n]) begin
        case (acc.off[3:0])
          4'h0:    rd_val = cmp[n];
          4'h4:    rd_val = period[n];
          4'h8:    rd_val = DW'({irq_en[n], per_mode[n], en[n]});
          default: rd_val = '0;
        endcase
      end
    end
  end
endmodule

// File: doc/timer_sched.md
TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of compare channels (1..8).
REQ-002 SHALL have parameter BASE, default 20'h00022, required value of data_addr[31:12] for decode.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports data_req, data_we  input  1 each  bus request and write strobe.
REQ-006 SHALL have port data_be  input  4  byte enables for writes.
REQ-007 SHALL have ports data_addr, data_wdata  input  32 each  address and write data.
REQ-008 SHALL have ports data_gnt, data_rvalid  output  1 each  grant and read/write completion.
REQ-009 SHALL have port data_rdata  output  32  read data, valid while data_rvalid=1.
REQ-010 SHALL have port irq  output  1  OR over channels of (pending & irq_en).

Function
REQ-011 SHALL decode a request when data_addr[31:12]==BASE; non-decoded requests are ignored entirely.
REQ-012 SHALL assert data_gnt for exactly one cycle, in the cycle after data_req&decode&~data_gnt.
REQ-013 SHALL assert data_rvalid for one cycle, the cycle after data_gnt, for reads and writes.
REQ-014 SHALL apply writes and capture read data in the cycle data_gnt is asserted; at most one access is in flight.
REQ-015 SHALL return 0 for reads of unmapped offsets; writes to unmapped or RO offsets SHALL have no effect.
REQ-016 SHALL implement map: 0x00 RO COUNT; 0x04 WO CTRL (bit0 reset count, bit1 run); 0x08 PEND (RO bits[N_CH-1:0], W1C); 0x0C RO STATUS (bit0 run, bits[11:8] lowest-index pending channel, 4'hF if none).
REQ-017 SHALL implement channel n at 0x10+0x10*n: +0x0 CMP RW, +0x4 PERIOD RW, +0x8 CCTRL RW (bit0 enable, bit1 periodic, bit2 irq_en); CMP and PERIOD SHALL honour data_be per byte; CCTRL SHALL use data_be[0].
REQ-018 SHALL increment the 32-bit COUNT by 1 each cycle while run=1, wrapping 0xFFFFFFFF->0.
REQ-019 SHALL, on CTRL write with bit0=1, load COUNT=0 the next cycle, overriding increment; run takes bit1 of the same write.
REQ-020 SHALL fire channel n when enable=1 and (COUNT-CMP) mod 2^32 has bit31 clear (wrap-safe "COUNT reached CMP").
REQ-021 SHALL, on fire, set PEND[n] the next cycle.
REQ-022 SHALL, on fire with periodic=1 and PERIOD!=0, set CMP<=CMP+PERIOD mod 2^32 and keep enable=1.
REQ-023 SHALL, on fire with periodic=0 or PERIOD==0, clear enable.
REQ-024 SHALL evaluate at most one fire per channel per cycle; multiple channels MAY fire in the same cycle.
REQ-025 SHALL let a same-cycle set win over a W1C clear of the same PEND bit.
REQ-026 SHALL let a same-cycle bus write to CMP or CCTRL win over the fire-driven CMP/enable update; PEND still sets.
REQ-027 SHALL drive irq combinationally from registered PEND and irq_en.

Reset
REQ-028 SHALL, while rst=0, force COUNT=0, run=0, all CMP/PERIOD/CCTRL/PEND=0, data_gnt=0, data_rvalid=0, data_rdata=0, irq=0.
REQ-029 SHALL abandon any in-flight access on reset; no rvalid follows a grant cut by reset.
REQ-030 SHALL, after rst deasserts, accept the first request with grant the next cycle.

Verification
REQ-031 SHALL cover: read 0x0C after reset -> gnt at T+1, rvalid at T+2, rdata=0x00000F00.
REQ-032 SHALL cover: CTRL=0x3, CH0 CMP=10, CCTRL=0x5 -> PEND=0x1, irq=1, CH0 enable cleared; W1C 0x1 to PEND -> irq=0.
REQ-033 SHALL cover: CH1 CMP=100, PERIOD=50, CCTRL=0x7 -> fires at COUNT 100,150,200; CMP reads 250 after third fire.
REQ-034 SHALL cover: COUNT near 0xFFFFFFF0, CMP=0x00000005 -> no fire before wrap; fires after COUNT reaches 5.
REQ-035 SHALL cover: W1C to PEND[0] in the same cycle CH0 fires -> PEND[0] remains 1.
REQ-036 SHALL cover: rst pulsed low mid-access and with PEND set -> all outputs 0 asynchronously, no rvalid issued.
